// File: rtl/add_sub_pkg.sv
// add_sub_pkg: op encoding and configuration helpers shared by the add_sub_pipe datapath.
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_width(input int data_len, input int seg_num);
        return (seg_num > 0) ? data_len / seg_num : data_len;
    endfunction

    function automatic bit seg_cfg_ok(input int data_len, input int seg_num);
        return (seg_num >= 1) && ((data_len % seg_num) == 0);
    endfunction

endpackage

// File: rtl/add_sub_seg.sv
// add_sub_seg: one combinational W-bit slice of the segmented carry chain.
module add_sub_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + (W+1)'(cin);

endmodule

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: adder/subtractor with the carry chain split into SEG_NUM registered segments,
// valid/ready flow control with bubble collapsing, and flush. ADD_SUB_PIPE_FLAG_EN adds zero/negative.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int SEG_NUM  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] OP_A,
    input  logic [DATA_LEN-1:0] OP_B,
    input  logic                Cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] Sum,
    output logic                Cout,
`ifdef ADD_SUB_PIPE_FLAG_EN
    output logic                zero,
    output logic                negative,
`endif
    output logic                overflow
);

    localparam int SEG_W  = seg_width(DATA_LEN, SEG_NUM);
    localparam bit CFG_OK = seg_cfg_ok(DATA_LEN, SEG_NUM);
    localparam int MSB    = DATA_LEN - 1;
    localparam int LAST   = SEG_NUM - 1;

    if (!CFG_OK) begin : g_cfg_check
        $error("add_sub_pipe: SEG_NUM must be >= 1 and divide DATA_LEN");
    end

    logic [SEG_NUM-1:0]  valid_r, valid_next, adv, load;
    logic [DATA_LEN-1:0] b_inv;

    logic [DATA_LEN-1:0] a_r   [SEG_NUM];
    logic [DATA_LEN-1:0] b_r   [SEG_NUM];
    logic [DATA_LEN-1:0] sum_r [SEG_NUM];
    logic                c_r   [SEG_NUM];
`ifdef ADD_SUB_PIPE_FLAG_EN
    logic                zero_r [SEG_NUM];
`endif

    always_comb begin
        b_inv = OP_B;
        case (Cin)
            OP_ADD: b_inv = OP_B;
            OP_SUB: b_inv = ~OP_B;
        endcase
    end

    // A stage moves when the stages above it contain a hole or the whole tail drains.
    always_comb begin
        logic full_above;
        // NOTE: combinational blocks use blocking '=' so full_above accumulates in loop order.
        full_above = 1'b1;
        adv        = '0;
        for (int k = SEG_NUM - 1; k >= 0; k--) begin
            adv[k]     = valid_r[k] & (out_ready | ~full_above);
            full_above = full_above & valid_r[k];
        end
    end

    assign in_ready = ~valid_r[0] | adv[0];

    always_comb begin
        load    = '0;
        load[0] = in_valid & in_ready;
        for (int k = 1; k < SEG_NUM; k++) begin
            load[k] = adv[k-1];
        end
        valid_next = load | (valid_r & ~adv);
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_r <= '0;
        end else begin
            valid_r <= valid_next;
        end
    end

    for (genvar k = 0; k < SEG_NUM; k++) begin : g_stage
        logic [DATA_LEN-1:0] a_in, b_in, sum_in;
        logic                c_in;
        logic [SEG_W-1:0]    seg_sum;
        logic                seg_cout;
`ifdef ADD_SUB_PIPE_FLAG_EN
        logic                z_in;
`endif

        if (k == 0) begin : g_head
            assign a_in   = OP_A;
            assign b_in   = b_inv;
            assign c_in   = Cin;
            assign sum_in = '0;
`ifdef ADD_SUB_PIPE_FLAG_EN
            assign z_in   = 1'b1;
`endif
        end else begin : g_body
            assign a_in   = a_r[k-1];
            assign b_in   = b_r[k-1];
            assign c_in   = c_r[k-1];
            assign sum_in = sum_r[k-1];
`ifdef ADD_SUB_PIPE_FLAG_EN
            assign z_in   = zero_r[k-1];
`endif
        end

        add_sub_seg #(.W(SEG_W)) u_seg (
            .a    (a_in[k*SEG_W +: SEG_W]),
            .b    (b_in[k*SEG_W +: SEG_W]),
            .cin  (c_in),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        // NOTE: only the output stage's data is reset, since it drives the ports; inner data is qualified by valid.
        always_ff @(posedge clk) begin
            if (rst && (k == LAST)) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
                c_r[k]   <= 1'b0;
            end else if (load[k]) begin
                a_r[k]                       <= a_in;
                b_r[k]                       <= b_in;
                c_r[k]                       <= seg_cout;
                sum_r[k]                     <= sum_in;
                sum_r[k][k*SEG_W +: SEG_W]   <= seg_sum;
            end
        end

`ifdef ADD_SUB_PIPE_FLAG_EN
        always_ff @(posedge clk) begin
            if (rst && (k == LAST)) begin
                zero_r[k] <= 1'b0;
            end else if (load[k]) begin
                zero_r[k] <= z_in & ~|seg_sum;
            end
        end
`endif
    end

    assign out_valid = valid_r[LAST];
    assign Sum       = sum_r[LAST];
    assign Cout      = c_r[LAST];
    assign overflow  = (a_r[LAST][MSB] == b_r[LAST][MSB]) & (a_r[LAST][MSB] != sum_r[LAST][MSB]);

`ifdef ADD_SUB_PIPE_FLAG_EN
    assign zero      = zero_r[LAST];
    assign negative  = sum_r[LAST][MSB];
`endif

endmodule

// File: tb/tb_add_sub_pipe.sv
// Testbench for add_sub_pipe at DATA_LEN=32, SEG_NUM=4: directed arithmetic, streaming,
// backpressure, flush and mid-flight reset.
module tb_add_sub_pipe;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, cin;
    logic         out_valid, out_ready, cout, overflow;
    logic [W-1:0] op_a, op_b, sum;
`ifdef ADD_SUB_PIPE_FLAG_EN
    logic         zero, negative;
    logic         obs_zero, obs_neg;
`endif

    logic [W-1:0] obs_sum;
    logic         obs_cout, obs_ovf, obs_acc;
    int           obs_lat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_sub_pipe #(.DATA_LEN(W), .SEG_NUM(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OP_A      (op_a),
        .OP_B      (op_b),
        .Cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .Cout      (cout),
`ifdef ADD_SUB_PIPE_FLAG_EN
        .zero      (zero),
        .negative  (negative),
`endif
        .overflow  (overflow)
    );

    // Reference: plain (W+1)-bit sum, returned as {overflow, carry, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] bb;
        logic [W:0]   r;
        logic         ov;
        bb = c ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
        ov = (a[W-1] == bb[W-1]) && (a[W-1] != r[W-1]);
        return {ov, r};
    endfunction

    // Offers one operation on an empty pipe and waits (bounded) for its result.
    task automatic issue_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        obs_lat = -1; obs_sum = '0; obs_cout = 1'b0; obs_ovf = 1'b0;
`ifdef ADD_SUB_PIPE_FLAG_EN
        obs_zero = 1'b0; obs_neg = 1'b0;
`endif
        #1;
        obs_acc = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (out_valid) begin
                obs_lat = n; obs_sum = sum; obs_cout = cout; obs_ovf = overflow;
`ifdef ADD_SUB_PIPE_FLAG_EN
                obs_zero = zero; obs_neg = negative;
`endif
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, sum, cout, overflow} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, want all zero", out_valid, sum, cout, overflow);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
`ifdef ADD_SUB_PIPE_FLAG_EN
        checks++;
        if ({zero, negative} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got zero=%b neg=%b want 0 0", zero, negative);
        end
`endif
    endtask

    typedef struct {
        logic [W-1:0] a, b, s;
        logic         c, co, ov, z, ng;
    } vec_t;

    task automatic test_arith();
        vec_t v [4];
        v[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, c: 1'b0, s: 32'h0000_0000, co: 1'b1, ov: 1'b0, z: 1'b1, ng: 1'b0};
        v[1] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, c: 1'b0, s: 32'h8000_0000, co: 1'b0, ov: 1'b1, z: 1'b0, ng: 1'b1};
        v[2] = '{a: 32'h8000_0000, b: 32'h0000_0001, c: 1'b1, s: 32'h7FFF_FFFF, co: 1'b1, ov: 1'b1, z: 1'b0, ng: 1'b0};
        v[3] = '{a: 32'h0000_0003, b: 32'h0000_0005, c: 1'b1, s: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b0, z: 1'b0, ng: 1'b1};
        for (int i = 0; i < 4; i++) begin
            issue_one(v[i].a, v[i].b, v[i].c);
            checks++;
            if (obs_acc !== 1'b1) begin
                errors++;
                $display("FAIL arith[%0d]_accept: in_ready=%b want 1", i, obs_acc);
            end
            checks++;
            if (obs_lat != N) begin
                errors++;
                $display("FAIL arith[%0d]_latency: got %0d cycles want %0d", i, obs_lat, N);
            end
            checks++;
            if ({obs_sum, obs_cout, obs_ovf} !== {v[i].s, v[i].co, v[i].ov}) begin
                errors++;
                $display("FAIL arith[%0d]_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, obs_sum, obs_cout, obs_ovf, v[i].s, v[i].co, v[i].ov);
            end
`ifdef ADD_SUB_PIPE_FLAG_EN
            checks++;
            if ({obs_zero, obs_neg} !== {v[i].z, v[i].ng}) begin
                errors++;
                $display("FAIL arith[%0d]_flags: got zero=%b neg=%b want %b %b", i, obs_zero, obs_neg, v[i].z, v[i].ng);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   va [16];
        logic [W-1:0]   vb [16];
        logic           vc [16];
        logic [W+1:0]   exp_q [$];
        logic [W+1:0]   e;
        int idx = 0, n_out = 0, first = -1, last = -1;
        for (int i = 0; i < 16; i++) begin
            va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            in_valid = (idx < 16);
            if (idx < 16) begin
                op_a = va[idx]; op_b = vb[idx]; cin = vc[idx];
            end
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: out_valid at cycle %0d with nothing outstanding", c);
                end else begin
                    e = exp_q.pop_front();
`ifdef ADD_SUB_PIPE_FLAG_EN
                    if ({overflow, cout, sum, zero, negative} !== {e, (e[W-1:0] == '0), e[W-1]}) begin
`else
                    if ({overflow, cout, sum} !== e) begin
`endif
                        errors++;
                        $display("FAIL b2b_result[%0d]: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 n_out, overflow, cout, sum, e[W+1], e[W], e[W-1:0]);
                    end
                end
                if (first < 0) first = c;
                last = c;
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(op_a, op_b, cin));
                idx++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_out != 16 || idx != 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, %0d accepted, want 16 and 16", n_out, idx);
        end
        checks++;
        if (first != N || last != N + 15) begin
            errors++;
            $display("FAIL b2b_throughput: results in cycles %0d..%0d want %0d..%0d", first, last, N, N + 15);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic [W+1:0] exp_q [$];
        logic [W+1:0] e;
        int idx = 0, n_out = 0;
        va = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h1234_5678, 32'h8000_0001, 32'h0F0F_0F0F, 32'h0000_0000};
        vb = '{32'h0000_0020, 32'h0000_0010, 32'h1111_1111, 32'h8000_0001, 32'h0101_0101, 32'h0000_0001};
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            out_ready = (c >= 10);
            in_valid  = (idx < 6);
            if (idx < 6) begin
                op_a = va[idx]; op_b = vb[idx]; cin = idx[0];
            end
            #1;
            if (c == 9) begin
                checks++;
                if (idx != 4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: accepted=%0d in_ready=%b out_valid=%b want 4 0 1", idx, in_ready, out_valid);
                end
            end
            if (c == 10) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_accept_and_drain: in_ready=%b want 1", in_ready);
                end
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_spurious: out_valid at cycle %0d with nothing outstanding", c);
                end else begin
                    e = out_ready ? exp_q.pop_front() : exp_q[0];
                    if ({overflow, cout, sum} !== e) begin
                        errors++;
                        $display("FAIL bp_result c%0d: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 c, overflow, cout, sum, e[W+1], e[W], e[W-1:0]);
                    end
                end
                if (out_ready) n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(op_a, op_b, cin));
                idx++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_out != 6 || idx != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d results, %0d accepted, want 6 and 6", n_out, idx);
        end
    endtask

    // kill_rst=0 exercises flush, kill_rst=1 exercises reset, both asserted in cycle 2.
    task automatic test_kill(input bit kill_rst);
        int seen = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 3);
            op_a = 32'h0000_1000 + 32'(c); op_b = 32'h0000_0100; cin = 1'b0;
            flush = !kill_rst && (c == 2);
            rst   = kill_rst && (c == 2);
            #1;
            if (c == 3 && kill_rst) begin
                checks++;
                if ({out_valid, sum, cout, overflow, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: valid=%b sum=%h cout=%b ovf=%b in_ready=%b want 0 0 0 0 1",
                             out_valid, sum, cout, overflow, in_ready);
                end
            end
            if (c >= 3 && out_valid) seen++;
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s_mid_flight: %0d results escaped, want 0", kill_rst ? "rst" : "flush", seen);
        end
        issue_one(32'h0000_00FF, 32'h0000_0001, 1'b0);
        checks++;
        if (obs_lat != N || {obs_sum, obs_cout, obs_ovf} !== {32'h0000_0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_recovery: lat=%0d sum=%h cout=%b ovf=%b want %0d 00000100 0 0",
                     kill_rst ? "rst" : "flush", obs_lat, obs_sum, obs_cout, obs_ovf, N);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_kill(1'b0);
        test_kill(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
Parametrised, pipelined adder/subtractor with Cin-as-subtract semantics, carry-out and signed overflow. The carry chain is split into SEG_NUM segments, one pipeline stage per segment, so wide operands close timing at high clock rates. It has a valid/ready handshake with per-stage bubble collapsing and a synchronous flush. It serves as the shared add/compare unit for ALU, address-generation and multi-cycle datapaths.

Parameters:
DATA_LEN, 32, operand and result width in bits.
SEG_NUM, 4, number of carry segments and pipeline stages. Must be at least 1, and DATA_LEN must be a multiple of SEG_NUM.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous kill of all in-flight operations.
in_valid  input  1  operands presented.
in_ready  output  1  stage 0 can accept this cycle.
OP_A  input  DATA_LEN  operand A.
OP_B  input  DATA_LEN  operand B.
Cin  input  1  0 = add (A+B), 1 = subtract (A+~B+1).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
Sum  output  DATA_LEN  result.
Cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
overflow  output  1  signed overflow.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Arithmetic, with SEG = DATA_LEN/SEG_NUM:
  - b = OP_B ^ {DATA_LEN{Cin}}.
  - Stage k adds a[k*SEG +: SEG] + b[k*SEG +: SEG] + carry_k.
  - carry_0 = Cin; carry_(k+1) is registered into stage k+1.
- Per-stage registers:
  - valid bit.
  - result segments already computed.
  - operand segments not yet consumed, plus a/b sign bits.
  - incoming carry.
- Final result:
  - Cout is the carry out of the top segment.
  - overflow = (a_msb == b_msb) & (a_msb != Sum_msb), with b after inversion.
  - The result is bit-identical to the combinational (DATA_LEN+1)-bit sum.
- Latency:
  - Stage 0 captures on in_valid & in_ready.
  - out_valid rises SEG_NUM cycles after acceptance.
  - With SEG_NUM=1, the result is registered once (1 cycle).
- Throughput: one operation per cycle when out_ready is held high.
- Handshake:
  - Stage k advances when valid[k] & (~valid[k+1] | advance[k+1]).
  - The last stage advances on out_ready.
  - in_ready = ~valid[0] | advance[0], so bubbles collapse and a stalled tail does not block an empty head.
  - in_ready may depend combinationally on out_ready; no other output does.
- Output hold: out_valid, Sum, Cout and overflow stay stable while out_valid & ~out_ready.
- Ordering: results leave in acceptance order; there is no reordering or dropping except by flush.
- Reset:
  - All valid bits clear.
  - out_valid=0, Sum=0, Cout=0, overflow=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight work.
- Flush:
  - Clears all valid bits on the next edge; data registers are don't-care.
  - A transfer offered in the flush cycle is discarded, whether in_valid or the output handshake.
  - rst has priority over flush.
- Boundary cases:
  - Carry ripples across every segment (e.g. 0xFFFFFFFF+1).
  - A full pipeline under backpressure holds every stage and de-asserts in_ready.
  - Simultaneous input accept and output drain in the same cycle with a full pipe must lose nothing.

Optional Feature:
- ADD_SUB_PIPE_FLAG_EN:
  - When defined, adds outputs zero (1 bit, Sum==0) and negative (1 bit, Sum MSB).
  - Both are registered with the result and valid exactly when out_valid; reset value 0.
  - zero is built from per-segment zero bits ANDed along the pipe, not from a wide compare at the output.
- Without the macro, the ports and logic are absent and the module is otherwise identical.

Decomposition:
- Shared package add_sub_pkg holds:
  - a SEG_W derivation helper and a localparam check that DATA_LEN % SEG_NUM == 0;
  - the op encoding constants OP_ADD=1'b0 and OP_SUB=1'b1.
- One natural sub-module, add_sub_seg: one combinational SEG-bit segment adder (a, b, cin → sum, cout). It is instantiated once per stage via generate.
- Stage registers and handshake logic stay in the top.

Test Plan:
All cases use DATA_LEN=32, SEG_NUM=4.
- Add with full ripple: A=0xFFFFFFFF, B=0x00000001, Cin=0 → after 4 cycles Sum=0x00000000, Cout=1, overflow=0 (zero=1 if flag enabled).
- Signed overflow on add and subtract:
  - 0x7FFFFFFF+1 → Sum=0x80000000, Cout=0, overflow=1.
  - Sub 0x80000000−1 → Sum=0x7FFFFFFF, Cout=1, overflow=1.
- Borrow: sub 3−5 → Sum=0xFFFFFFFE, Cout=0, overflow=0 (negative=1).
- Back-to-back stream: 16 random ops with out_ready=1 → one result per cycle, in order, all matching the reference model.
- Backpressure:
  - Hold out_ready=0 while issuing 6 ops → exactly 4 accepted, then in_ready=0 and outputs stable.
  - Release out_ready → the remaining 2 ops are accepted as slots free; all 6 results arrive in order.
- Flush and reset mid-flight: issue 3 ops, assert flush on cycle 2 → no out_valid afterwards. Repeat with rst → all outputs 0 and in_ready=1 on the following cycle.
